// File: rtl/chi_tx_link_ctrl_if.sv
// Signal bundle between the bridge flit buffer, the TX link controller and the CHI TX pins.
// The master modport is the controller's view; slave is the mirror seen by its surroundings.
interface chi_tx_link_ctrl_if #(
    parameter int FLIT_WIDTH = 64
);
    logic                  in_valid;
    logic                  in_ready;
    logic [FLIT_WIDTH-1:0] in_flit;
    logic                  txlinkactivereq;
    logic                  txlinkactiveack;
    logic                  txlcrdv;
    logic                  txflitpend;
    logic                  txflitv;
    logic [FLIT_WIDTH-1:0] txflit;
    logic                  link_flit;

    modport master (
        input  in_valid, in_flit, txlinkactiveack, txlcrdv,
        output in_ready, txlinkactivereq, txflitpend, txflitv, txflit, link_flit
    );

    modport slave (
        output in_valid, in_flit, txlinkactiveack, txlcrdv,
        input  in_ready, txlinkactivereq, txflitpend, txflitv, txflit, link_flit
    );
endinterface

// File: rtl/chi_tx_link_ctrl.sv
// CHI TX channel link-layer controller: TXLINKACTIVE handshake, L-credit tracking,
// credit-gated flit issue and credit return with link flits during deactivation.
module chi_tx_link_ctrl #(
    parameter int FLIT_WIDTH  = 64,
    parameter int MAX_CREDITS = 15,
    parameter int CRD_W       = 4
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                link_en,
    chi_tx_link_ctrl_if.master  bus,
    output logic [1:0]          link_state,
    output logic [CRD_W-1:0]    credit_cnt,
    output logic                proto_err
);

    typedef enum logic [1:0] {
        ST_STOP       = 2'd0,
        ST_ACTIVATE   = 2'd1,
        ST_RUN        = 2'd2,
        ST_DEACTIVATE = 2'd3
    } state_e;

    state_e                state_q, state_d;
    logic [CRD_W-1:0]      crd_q, crd_d;
    logic                  err_q, err_d;
    logic                  req_q, req_d;
    logic                  pend_q, pend_d;
    logic                  flitv_q, flitv_d;
    logic                  link_flit_q, link_flit_d;
    logic [FLIT_WIDTH-1:0] flit_q, flit_d;

    logic have_crd;
    logic accept;
    logic ret;
    logic crd_inc;
    logic crd_dec;
    logic crd_full;

    assign have_crd = (crd_q != '0);
    assign accept   = bus.in_valid && (state_q == ST_RUN) && have_crd;
    assign ret      = (state_q == ST_DEACTIVATE) && have_crd;
    assign crd_dec  = accept || ret;
    assign crd_inc  = bus.txlcrdv && (state_q != ST_STOP);
    assign crd_full = (crd_q == CRD_W'(MAX_CREDITS));

    always_comb begin
        // NOTE: every signal gets its default first so no path through the case leaves it unassigned (no latch).
        state_d     = state_q;
        crd_d       = crd_q;
        err_d       = err_q;
        flitv_d     = crd_dec;
        link_flit_d = ret;
        flit_d      = accept ? bus.in_flit : flit_q;

        unique case (state_q)
            ST_STOP:       if (link_en && !bus.txlinkactiveack) state_d = ST_ACTIVATE;
            ST_ACTIVATE:   if (bus.txlinkactiveack)             state_d = ST_RUN;
            ST_RUN:        if (!link_en)                        state_d = ST_DEACTIVATE;
            // A credit arriving on the last cycle must be returned before STOP, so it blocks the exit too.
            ST_DEACTIVATE: if (!bus.txlinkactiveack && !have_crd && !crd_inc && !crd_dec)
                               state_d = ST_STOP;
            default:       state_d = ST_STOP;
        endcase

        if (crd_inc && !crd_dec) begin
            if (!crd_full) crd_d = crd_q + CRD_W'(1);
        end else if (crd_dec && !crd_inc) begin
            crd_d = crd_q - CRD_W'(1);
        end

        if (bus.txlcrdv && (state_q == ST_STOP))            err_d = 1'b1;
        if (crd_inc && !crd_dec && crd_full)                 err_d = 1'b1;
        if ((state_q == ST_RUN) && !bus.txlinkactiveack)     err_d = 1'b1;

        req_d  = (state_d == ST_ACTIVATE) || (state_d == ST_RUN);
        pend_d = (state_d == ST_RUN) || (state_d == ST_DEACTIVATE);
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking updates so every flop samples the same pre-edge values.
        if (!resetn) begin
            state_q     <= ST_STOP;
            crd_q       <= '0;
            err_q       <= 1'b0;
            req_q       <= 1'b0;
            pend_q      <= 1'b0;
            flitv_q     <= 1'b0;
            link_flit_q <= 1'b0;
            flit_q      <= '0;
        end else begin
            state_q     <= state_d;
            crd_q       <= crd_d;
            err_q       <= err_d;
            req_q       <= req_d;
            pend_q      <= pend_d;
            flitv_q     <= flitv_d;
            link_flit_q <= link_flit_d;
            flit_q      <= flit_d;
        end
    end

    assign bus.in_ready        = (state_q == ST_RUN) && have_crd;
    assign bus.txlinkactivereq = req_q;
    assign bus.txflitpend      = pend_q;
    assign bus.txflitv         = flitv_q;
    assign bus.txflit          = flit_q;
    assign bus.link_flit       = link_flit_q;
    assign link_state          = state_q;
    assign credit_cnt          = crd_q;
    assign proto_err           = err_q;

endmodule
